add32_cla_seq: RTL and testbench
================================

ADD32_CLA_SEQ -- requirements
Module: add32_cla_seq

Interface
REQ-001 SHALL have parameter SUB_EN, default 1: 1 enables subtract mode; 0 forces sub to be treated as 0.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  operand set present.
REQ-006 in_ready  out  1  block accepts operands.
REQ-007 a  in  32  operand A.
REQ-008 b  in  32  operand B.
REQ-009 sub  in  1  0 = add, 1 = subtract.
REQ-010 cin  in  1  carry-in for add; borrow-in for subtract.
REQ-011 out_valid  out  1  result registers hold a completed result.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 sum  out  32  registered result.
REQ-014 cout  out  1  raw carry out of bit 31.
REQ-015 ovf  out  1  signed overflow.
REQ-016 zero  out  1  sum == 0.
REQ-017 grp_p_n  out  1  active-low 32-bit group propagate, for cascading into a lookahead generator.
REQ-018 grp_g_n  out  1  active-low 32-bit group generate, for cascading into a lookahead generator.

Function
REQ-019 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, on in_valid=1, SHALL capture operand bits at the edge:
  - a
  - b' = sub ? ~b : b
  - c0 = sub ? ~cin : cin
  - then go to LO.
REQ-022 Per-bit terms SHALL be p_i = a_i | b'_i and g_i = a_i & b'_i.
REQ-023 Each 4-bit nibble SHALL form its own group P and G.
REQ-024 Nibble carries SHALL use 74182-style lookahead equations, with no ripple between nibbles.
REQ-025 LO SHALL register:
  - sum[15:0]
  - carry c16
  - low-half group P and G
  - then go to HI unconditionally.
REQ-026 HI SHALL compute bits 31:16 using registered c16 and register:
  - sum[31:16]
  - cout = c32
  - ovf = c31 ^ c32
  - zero
  - grp_p_n = ~(AND of all p_i)
  - grp_g_n = ~(carry out of bit 31 with c0 forced to 0)
  - then go to DONE.
REQ-027 Latency: operands accepted at edge k SHALL give out_valid=1 after edge k+2.
REQ-028 In DONE, out_valid SHALL be 1 and all result outputs SHALL hold stable.
REQ-029 DONE SHALL go to IDLE at the edge where out_ready=1.
REQ-030 out_valid SHALL drop in the following cycle.
REQ-031 DONE SHALL NOT accept a new operand set in the same cycle; minimum issue interval is 4 cycles.
REQ-032 in_valid SHALL be ignored in LO, HI and DONE; operand changes there SHALL NOT affect the result.
REQ-033 out_ready SHALL be ignored outside DONE.
REQ-034 When SUB_EN=0, sub SHALL have no effect.
REQ-035 Subtract SHALL compute a - b - cin modulo 2^32.
REQ-036 cout SHALL NOT be inverted for subtract; cout=1 means no borrow.

Reset
REQ-037 rst=1 at an edge SHALL force:
  - state IDLE
  - out_valid=0
  - sum=0, cout=0, ovf=0, zero=0
  - grp_p_n=1, grp_g_n=1
  - this has priority over all other inputs.
REQ-038 Reset in LO, HI or DONE SHALL abort the operation; no out_valid for it, ever.
REQ-039 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-040 Cross-half carry: a=0x0000FFFF, b=1, cin=0, sub=0 -> sum=0x00010000, cout=0, ovf=0, zero=0; out_valid after edge k+2.
REQ-041 Wrap: a=0xFFFFFFFF, b=1, cin=0 -> sum=0, cout=1, zero=1, ovf=0, grp_p_n=0, grp_g_n=0.
REQ-042 Subtract: a=5, b=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0; repeat with SUB_EN=0 -> sum=0x0000000C.
REQ-043 Overflow: a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, ovf=1, cout=0.
REQ-044 Backpressure:
  - hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b.
  - out_valid stays 1, sum stays unchanged, in_ready stays 0.
  - first out_ready=1 edge -> IDLE.
REQ-045 Reset mid-op: assert rst for 1 cycle while in HI -> next cycle out_valid=0, in_ready=1, sum=0; no result emitted.

Source files
------------

// File: rtl/add32_cla_seq.sv
// 32-bit carry-lookahead add/subtract, two 16-bit halves over consecutive cycles.
// One 16-bit nibble/74182 datapath is shared between the LO and HI phases.

module add32_cla_seq_nib (
  input  logic [3:0] i_p,
  input  logic [3:0] i_g,
  input  logic [3:0] i_t,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_p,
  output logic       o_g,
  output logic       o_c3
);
  logic [3:0] w_c;

  assign w_c[0] = i_c;
  assign w_c[1] = i_g[0] | (i_p[0] & i_c);
  assign w_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
  assign w_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c);
  assign o_s  = i_t ^ w_c;
  assign o_c3 = w_c[3];
  assign o_p  = &i_p;
  assign o_g  = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
              | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
endmodule

// 74182-style generator: nibble carries come straight from group terms.
module add32_cla_seq_lcu (
  input  logic [3:0] i_p,
  input  logic [3:0] i_g,
  input  logic       i_c,
  output logic [3:1] o_c,
  output logic       o_p,
  output logic       o_g
);
  assign o_c[1] = i_g[0] | (i_p[0] & i_c);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c);
  assign o_p    = &i_p;
  assign o_g    = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
endmodule

module add32_cla_seq #(
  parameter bit SUB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        zero,
  output logic        grp_p_n,
  output logic        grp_g_n
);
  localparam int NIB = 4;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_a, r_b, r_sum;
  logic        r_c0, r_c16, r_pl, r_gl;
  logic        r_out_valid, r_cout, r_ovf, r_zero, r_pn, r_gn;

  logic              w_sub, w_hi, w_cin, w_gp, w_gg, w_cout;
  logic [15:0]       w_ha, w_hb, w_p, w_g, w_t, w_s;
  logic [NIB-1:0]    w_np, w_ng, w_c3;
  logic [NIB-1:0]    w_nc;
  logic [3:1]        w_lc;

  assign w_sub = SUB_EN ? sub : 1'b0;
  assign w_hi  = (r_state == HI);
  assign w_ha  = w_hi ? r_a[31:16] : r_a[15:0];
  assign w_hb  = w_hi ? r_b[31:16] : r_b[15:0];
  assign w_cin = w_hi ? r_c16 : r_c0;
  assign w_p   = w_ha | w_hb;
  assign w_g   = w_ha & w_hb;
  assign w_t   = w_ha ^ w_hb;

  assign w_nc[0]     = w_cin;
  assign w_nc[3:1]   = w_lc;

  genvar n;
  generate
    for (n = 0; n < NIB; n++) begin : g_nib
      add32_cla_seq_nib u_nib (
        .i_p  (w_p[4*n +: 4]),
        .i_g  (w_g[4*n +: 4]),
        .i_t  (w_t[4*n +: 4]),
        .i_c  (w_nc[n]),
        .o_s  (w_s[4*n +: 4]),
        .o_p  (w_np[n]),
        .o_g  (w_ng[n]),
        .o_c3 (w_c3[n])
      );
    end
  endgenerate

  add32_cla_seq_lcu u_lcu (
    .i_p (w_np),
    .i_g (w_ng),
    .i_c (w_cin),
    .o_c (w_lc),
    .o_p (w_gp),
    .o_g (w_gg)
  );

  assign w_cout = w_gg | (w_gp & w_cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_sum       <= 32'd0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_pn        <= 1'b1;
      r_gn        <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= w_sub ? ~b : b;
          r_c0    <= w_sub ? ~cin : cin;
          r_state <= LO;
        end
        LO: begin
          r_sum[15:0] <= w_s;
          r_c16       <= w_cout;
          r_pl        <= w_gp;
          r_gl        <= w_gg;
          r_state     <= HI;
        end
        HI: begin
          r_sum[31:16] <= w_s;
          r_cout       <= w_cout;
          // carry into bit 31 is nibble 3's internal c3 in the high half
          r_ovf        <= w_c3[NIB-1] ^ w_cout;
          r_zero       <= (r_sum[15:0] == 16'd0) && (w_s == 16'd0);
          r_pn         <= ~(r_pl & w_gp);
          r_gn         <= ~(w_gg | (w_gp & r_gl));
          r_out_valid  <= 1'b1;
          r_state      <= DONE;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign grp_p_n   = r_pn;
  assign grp_g_n   = r_gn;
endmodule

// File: tb/tb_add32_cla_seq.sv
// Bench for add32_cla_seq: arithmetic model plus directed vectors, two DUTs
// sharing stimulus (SUB_EN=1 and SUB_EN=0).

module tb_add32_cla_seq;
  logic        clk, rst, in_valid, sub, cin, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cout, ovf, zero, pn, gn;
  logic [31:0] sum;
  logic        in_ready0, out_valid0, cout0, ovf0, zero0, pn0, gn0;
  logic [31:0] sum0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic cout, ovf, zero, pn, gn;
  } res_t;

  add32_cla_seq #(.SUB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
    .grp_p_n(pn), .grp_g_n(gn));

  add32_cla_seq #(.SUB_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid0),
    .out_ready(out_ready), .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0),
    .grp_p_n(pn0), .grp_g_n(gn0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Plain 33-bit arithmetic; group generate is the carry out with no carry-in.
  function automatic res_t model(input logic [31:0] ma, mb, input logic ms, mc);
    res_t r;
    logic [31:0] bb;
    logic        c0;
    logic [32:0] f, g;
    bb = ms ? ~mb : mb;
    c0 = ms ? ~mc : mc;
    f = {1'b0, ma} + {1'b0, bb} + {32'd0, c0};
    g = {1'b0, ma} + {1'b0, bb};
    r.sum  = f[31:0];
    r.cout = f[32];
    r.ovf  = (ma[31] == bb[31]) && (f[31] != ma[31]);
    r.zero = (f[31:0] == 32'd0);
    r.pn   = ~&(ma | bb);
    r.gn   = ~g[32];
    return r;
  endfunction

  // Transaction-level model: busy from acceptance until the release edge;
  // the result becomes visible two edges after acceptance.
  logic m_init = 1'b0, m_busy = 1'b0, m_rst_vals = 1'b0;
  int   m_age = 0;
  res_t m_r1, m_r0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_rst_vals <= 1'b1; m_init <= 1'b1;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1; m_age <= 0; m_rst_vals <= 1'b0;
        m_r1 <= model(a, b, sub, cin);
        m_r0 <= model(a, b, 1'b0, cin);
      end
    end else if (m_age >= 2) begin
      if (out_ready) m_busy <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", in_ready, !m_busy);
      chk("in_ready0", in_ready0, !m_busy);
      chk("out_valid", out_valid, m_busy && m_age >= 2);
      chk("out_valid0", out_valid0, m_busy && m_age >= 2);
      if (m_busy && m_age >= 2) begin
        chk("res", {sum, cout, ovf, zero, pn, gn}, m_r1);
        chk("res0", {sum0, cout0, ovf0, zero0, pn0, gn0}, m_r0);
      end else if (m_rst_vals) begin
        chk("rst_res", {sum, cout, ovf, zero, pn, gn}, {32'd0, 5'b00011});
        chk("rst_res0", {sum0, cout0, ovf0, zero0, pn0, gn0}, {32'd0, 5'b00011});
      end
    end
  end

  task automatic do_op(input logic [31:0] ta, tbv, input logic ts, tc,
                       input logic [31:0] es, es0, input logic ec, eo, ez,
                       input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", n < 20, 1);
    a = ta; b = tbv; sub = ts; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_lo", out_valid, 0);
    // garbage while busy, plus out_ready outside DONE
    in_valid = 1'b1; a = $urandom; b = $urandom; sub = ~ts; cin = ~tc; out_ready = 1'b1;
    @(negedge clk);
    chk("lat_hi", out_valid, 0);
    out_ready = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    chk("lat_done", out_valid, 1);
    chk("sum_lit", sum, es);
    chk("sum0_lit", sum0, es0);
    chk("flags_lit", {cout, ovf, zero}, {29'd0, ec, eo, ez});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, es);
      chk("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_sum", sum, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_pg", {pn, gn}, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);

    chk("model_cross", model(32'h0000FFFF, 32'd1, 1'b0, 1'b0), {32'h00010000, 5'b00011});
    chk("model_wrap", model(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0), {32'h0, 5'b10100});
    chk("model_sub", model(32'd5, 32'd7, 1'b1, 1'b0).sum, 32'hFFFFFFFE);
    chk("model_ovf", model(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0).ovf, 1);

    //    a             b             sub   cin   sum           sum(SUB_EN=0) cout ovf zero hold
    do_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 0, 0, 0, 0);
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1, 0, 1, 0);
    chk("wrap_pg", {pn, gn}, 2'b00);
    do_op(32'd5,        32'd7,        1'b1, 1'b0, 32'hFFFFFFFE, 32'h0000000C, 0, 0, 0, 5);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 0, 1, 0, 0);
    do_op(32'd10,       32'd3,        1'b1, 1'b1, 32'h00000006, 32'h0000000E, 1, 0, 0, 2);
    do_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h80000001, 1, 1, 0, 0);
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 32'h2345678A, 0, 0, 0, 1);

    // reset while in HI aborts the operation
    a = 32'h0000FFFF; b = 32'd1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_sum", sum, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 0);
    end

    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
